// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered one-hot bus multiplexer with multi-driver conflict detection.
// Define BUS_PARITY_EN to add the registered bus_parity output.
module bus_arbiter_mux #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 24,
  parameter int SELW      = 5,
  parameter bit HOLD_LAST = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  stall,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SELW-1:0]       bus_sel,
  output logic                  conflict,
`ifdef BUS_PARITY_EN
  output logic                  bus_parity,
`endif
  output logic [7:0]            conflict_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, FAULT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] bus_q, bus_d, pick, idle_bus;
  logic [SELW-1:0]  sel_q, sel_d, idx;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d, conf_q, conf_d, any, multi;
  // Descending scan so the lowest enabled source wins idx/pick.
  always_comb begin
    any   = 1'b0;
    multi = 1'b0;
    idx   = '0;
    pick  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        multi = multi | any;
        any   = 1'b1;
        idx   = SELW'(i);
        pick  = src_data[i*WIDTH +: WIDTH];
      end
    end
  end
  assign idle_bus = HOLD_LAST ? bus_q : '0;
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    conf_d  = 1'b0;
    if (!stall) begin
      valid_d = 1'b0;
      if (!any) begin
        state_d = IDLE;
        bus_d   = idle_bus;
      end else if (state_q != FAULT && !multi) begin
        state_d = DRIVE;
        bus_d   = pick;
        sel_d   = idx;
        valid_d = 1'b1;
      end else if (state_q != FAULT) begin
        state_d = FAULT;
        conf_d  = 1'b1;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 8'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      bus_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef BUS_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) par_q <= 1'b0;
    else     par_q <= ^bus_d;
  end
  assign bus_parity = par_q;
`endif
  assign bus_out      = bus_q;
  assign bus_valid    = valid_q;
  assign bus_sel      = sel_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: randomized self-checking bench with a behavioural model; two DUTs cover HOLD_LAST=1 and 0.
module tb_bus_arbiter_mux;
  localparam int W = 32, N = 24, S = 5;
  logic             clk = 1'b0, clr = 1'b1, stall = 1'b0;
  logic [N*W-1:0]   src_data = '0;
  logic [N-1:0]     src_out = '0;
  logic [W-1:0]     bus_out, bus_out0;
  logic [S-1:0]     bus_sel, bus_sel0;
  logic [7:0]       conflict_cnt, conflict_cnt0;
  logic             bus_valid, bus_valid0, conflict, conflict0;
`ifdef BUS_PARITY_EN
  logic             par1, par0;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_bus1, m_bus0;
  logic [S-1:0] m_sel;
  logic [7:0]   m_cnt;
  logic         m_valid, m_conf, m_fault;
  logic [78:0]  got, exp_v;

  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .SELW(S), .HOLD_LAST(1)) dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .stall(stall),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_sel(bus_sel), .conflict(conflict),
`ifdef BUS_PARITY_EN
    .bus_parity(par1),
`endif
    .conflict_cnt(conflict_cnt));

  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .SELW(S), .HOLD_LAST(0)) dut0 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .stall(stall),
    .bus_out(bus_out0), .bus_valid(bus_valid0), .bus_sel(bus_sel0), .conflict(conflict0),
`ifdef BUS_PARITY_EN
    .bus_parity(par0),
`endif
    .conflict_cnt(conflict_cnt0));

  always #5 clk = ~clk;

  assign got   = {bus_out, bus_valid, bus_sel, conflict, conflict_cnt, bus_out0};
  assign exp_v = {m_bus1, m_valid, m_sel, m_conf, m_cnt, m_bus0};

  task automatic model_reset();
    m_bus1 = '0; m_bus0 = '0; m_sel = '0; m_cnt = '0;
    m_valid = 1'b0; m_conf = 1'b0; m_fault = 1'b0;
  endtask

  task automatic tick();
    logic [N-1:0] lsb;
    int n, low;
    @(posedge clk);
    m_conf = 1'b0;
    if (!stall) begin
      n   = $countones(src_out);
      lsb = src_out & (~src_out + 1'b1);
      low = $clog2(lsb);
      m_valid = 1'b0;
      if (n == 0) begin
        m_fault = 1'b0;
        m_bus0  = '0;
      end else if (!m_fault && n == 1) begin
        m_bus1 = src_data[low*W +: W];
        m_bus0 = m_bus1;
        m_sel  = S'(low);
        m_valid = 1'b1;
      end else if (!m_fault) begin
        m_fault = 1'b1;
        m_conf  = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    if (got !== 79'd0) begin
      n_bad++; $display("FAIL reset_initial: got %h exp 0", got);
    end
    n_cmp++;
    model_reset();
    @(posedge clk); #1 clr = 1'b0;
    src_data[0 +: W] = 32'hDEADBEEF; src_out = 24'h1;
    tick();
    if (got !== exp_v || bus_out !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL reset_pre_drive: got %h exp %h", got, exp_v);
    end
    n_cmp++;
    #3 clr = 1'b1;
    #1;
    model_reset();
    if (got !== 79'd0) begin
      n_bad++; $display("FAIL reset_async: got %h exp 0", got);
    end
    n_cmp++;
    #2 clr = 1'b0;
    src_out = '0;
    tick();
    if (got !== exp_v) begin
      n_bad++; $display("FAIL reset_idle_after: got %h exp %h", got, exp_v);
    end
    n_cmp++;
  endtask

  task automatic test_single();
    src_data[5*W +: W] = 32'h12345678; src_out = 24'h1 << 5;
    tick();
    if (got !== exp_v || bus_out !== 32'h12345678 || bus_sel !== 5'd5 || bus_valid !== 1'b1) begin
      n_bad++; $display("FAIL single_capture: got %h exp %h", got, exp_v);
    end
    n_cmp++;
    src_out = '0;
    tick();
    if (got !== exp_v || bus_out !== 32'h12345678 || bus_out0 !== 32'h0 || bus_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_release: got %h exp %h", got, exp_v);
    end
    n_cmp++;
  endtask

  task automatic test_conflict();
    int pulses = 0;
    src_out = (24'h1 << 3) | (24'h1 << 7);
    for (int c = 0; c < 3; c++) begin
      tick();
      pulses += int'(conflict);
      if (got !== exp_v || bus_valid !== 1'b0) begin
        n_bad++; $display("FAIL conflict_cycle%0d: got %h exp %h", c, got, exp_v);
      end
      n_cmp++;
    end
    if (pulses != 1 || conflict_cnt !== 8'd1) begin
      n_bad++; $display("FAIL conflict_pulse: pulses %0d cnt %0d exp 1/1", pulses, conflict_cnt);
    end
    n_cmp++;
    src_out = '0;
    tick();
    if (got !== exp_v) begin
      n_bad++; $display("FAIL conflict_exit: got %h exp %h", got, exp_v);
    end
    n_cmp++;
    src_data[2*W +: W] = 32'hA5A50002; src_out = 24'h1 << 2;
    tick();
    if (got !== exp_v || bus_sel !== 5'd2 || bus_valid !== 1'b1) begin
      n_bad++; $display("FAIL conflict_recover: got %h exp %h", got, exp_v);
    end
    n_cmp++;
  endtask

  task automatic test_stall();
    src_data[4*W +: W] = 32'h44440004; src_out = 24'h1 << 4; stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (got !== exp_v || bus_sel !== 5'd2) begin
        n_bad++; $display("FAIL stall_hold%0d: got %h exp %h", c, got, exp_v);
      end
      n_cmp++;
    end
    stall = 1'b0;
    tick();
    if (got !== exp_v || bus_out !== 32'h44440004 || bus_sel !== 5'd4) begin
      n_bad++; $display("FAIL stall_release: got %h exp %h", got, exp_v);
    end
    n_cmp++;
    stall = 1'b1; src_out = 24'h3;
    tick();
    if (got !== exp_v || conflict !== 1'b0 || conflict_cnt !== 8'd1) begin
      n_bad++; $display("FAIL stall_conflict: got %h exp %h", got, exp_v);
    end
    n_cmp++;
    stall = 1'b0; src_out = '0;
    tick();
    if (got !== exp_v) begin
      n_bad++; $display("FAIL stall_after: got %h exp %h", got, exp_v);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int a, b;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) src_data[i*W +: W] = $urandom;
      a = $urandom_range(0, N - 1);
      b = (a + $urandom_range(1, N - 1)) % N;
      case ($urandom_range(0, 3))
        0: src_out = '0;
        1: src_out = 24'h1 << a;
        2: src_out = (24'h1 << a) | (24'h1 << b);
        default: src_out = N'($urandom);
      endcase
      stall = ($urandom_range(0, 7) == 0);
      tick();
      if (got !== exp_v) begin
        n_bad++; $display("FAIL random%0d: got %h exp %h", c, got, exp_v);
      end
      n_cmp++;
`ifdef BUS_PARITY_EN
      if (par1 !== ^m_bus1 || par0 !== ^m_bus0) begin
        n_bad++; $display("FAIL random_parity%0d: got %b%b exp %b%b", c, par1, par0, ^m_bus1, ^m_bus0);
      end
      n_cmp++;
`endif
    end
    stall = 1'b0; src_out = '0;
    tick();
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int c = 0; c < 260; c++) begin
      src_out = (24'h1 << 1) | (24'h1 << 20);
      tick();
      pulses += int'(conflict);
      if (got !== exp_v) begin
        n_bad++; $display("FAIL sat_conflict%0d: got %h exp %h", c, got, exp_v);
      end
      n_cmp++;
      src_out = '0;
      tick();
      if (got !== exp_v) begin
        n_bad++; $display("FAIL sat_idle%0d: got %h exp %h", c, got, exp_v);
      end
      n_cmp++;
    end
    if (conflict_cnt !== 8'd255 || conflict_cnt0 !== 8'd255 || pulses != 260) begin
      n_bad++; $display("FAIL saturation: cnt %0d pulses %0d exp 255/260", conflict_cnt, pulses);
    end
    n_cmp++;
  endtask

`ifdef BUS_PARITY_EN
  task automatic test_parity();
    src_data[0 +: W] = 32'h7; src_out = 24'h1;
    tick();
    if (par1 !== 1'b1 || par0 !== 1'b1) begin
      n_bad++; $display("FAIL parity_7: got %b%b exp 11", par1, par0);
    end
    n_cmp++;
    src_data[0 +: W] = 32'h3;
    tick();
    if (par1 !== 1'b0 || par0 !== 1'b0) begin
      n_bad++; $display("FAIL parity_3: got %b%b exp 00", par1, par0);
    end
    n_cmp++;
    src_out = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_stall();
    test_random();
    test_saturation();
`ifdef BUS_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Registered, parametrised successor to the datapath's combinational bus multiplexer.
- Sources are selected by one-hot out-enables (R0out…Cout style) rather than a pre-encoded select.
- An internal priority encoder and a small ownership FSM detect multi-driver conflicts and count them.
- Sits between the register file / special registers and every bus consumer; all bus reads see a 1-cycle latency.

Parameters:
- WIDTH, 32: bus and source data width in bits.
- NSRC, 24: number of bus sources; minimum 2.
- SELW, 5: width of the encoded select output; must satisfy 2^SELW >= NSRC.
- HOLD_LAST, 1: 1 = bus_out keeps its last value when undriven; 0 = bus_out clears to 0 when undriven.

Ports:
- clk, input, 1: system clock, rising edge.
- clr, input, 1: asynchronous, active-high reset.
- src_data, input, NSRC*WIDTH: flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_out, input, NSRC: per-source out-enable, one-hot expected.
- stall, input, 1: freeze all state for the cycle.
- bus_out, output, WIDTH: registered bus value.
- bus_valid, output, 1: high when bus_out holds data captured from exactly one driver.
- bus_sel, output, SELW: index of the source captured into bus_out.
- conflict, output, 1: single-cycle pulse on entry to FAULT.
- conflict_cnt, output, 8: saturating count of FAULT entries.

Behaviour:
- Reset (clr high, asynchronous, independent of clk):
  - state = IDLE; bus_out = 0; bus_valid = 0; bus_sel = 0; conflict = 0; conflict_cnt = 0.
  - Reset asserted mid-operation aborts immediately; no partial capture survives.
- Latency: src_out/src_data sampled on rising edge N appear on the outputs after edge N. There is no combinational path from inputs to outputs.
- Encoder: count = popcount(src_out); idx = lowest set bit of src_out.
- FSM states: IDLE, DRIVE, FAULT. Evaluated only when stall = 0.
  - IDLE or DRIVE, count = 0:
    - Go to IDLE; bus_valid <= 0.
    - bus_out holds if HOLD_LAST = 1, else bus_out <= 0.
    - bus_sel holds.
  - IDLE or DRIVE, count = 1:
    - Go to DRIVE; bus_out <= source idx; bus_sel <= idx; bus_valid <= 1.
  - IDLE or DRIVE, count >= 2:
    - Go to FAULT; conflict <= 1 for one cycle.
    - conflict_cnt += 1, saturating at 255.
    - bus_valid <= 0; bus_out and bus_sel hold.
  - FAULT, count != 0:
    - Stay in FAULT; bus_valid = 0; no further count or pulse, even if a single driver appears.
  - FAULT, count = 0:
    - Go to IDLE; HOLD_LAST rule applies to bus_out.
- conflict is low in every cycle not described above.
- stall = 1:
  - All registers hold, including state and conflict_cnt.
  - conflict is forced to 0 during stall; a pulse pending at stall onset is not repeated.
  - Inputs during stall are ignored entirely.
- Back-to-back different single drivers: DRIVE→DRIVE, with bus_out updated every cycle.
- Saturation: at conflict_cnt = 255 further conflicts still pulse conflict but leave the count at 255.
- src_out bits at index >= NSRC do not exist. bus_sel never exceeds NSRC-1.

Optional Feature:
- Macro: BUS_PARITY_EN.
- Defined:
  - Adds output bus_parity (1 bit) = XOR of bus_out, registered in the same cycle as bus_out. Reset 0.
  - Holds under stall and in FAULT.
  - When HOLD_LAST = 0 and bus_out clears, bus_parity = 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: clr = 1 asynchronously mid-cycle while in DRIVE with bus_out = 32'hDEADBEEF → all outputs 0 immediately and state IDLE, with no clk edge needed.
- Single driver: src_out = 1<<5, source 5 = 32'h12345678 → next cycle bus_out = 32'h12345678, bus_sel = 5, bus_valid = 1. Then src_out = 0 → bus_valid = 0 and bus_out still 32'h12345678 (HOLD_LAST = 1); rerun with HOLD_LAST = 0 → bus_out = 0.
- Conflict: src_out = (1<<3)|(1<<7) for 3 cycles, then 0, then 1<<2 →
  - conflict high exactly one cycle; conflict_cnt = 1; bus_valid = 0 for the 3 cycles.
  - FAULT exits to IDLE on the zero cycle.
  - Source 2 is captured the following cycle.
- Stall: src_out = 1<<4 with stall = 1 for 2 cycles → outputs unchanged. Release stall → source 4 captured one cycle later. A conflict presented only while stalled → conflict_cnt unchanged.
- Saturation: 260 separate conflict/idle pairs → conflict_cnt = 255 and conflict pulses all 260 times.
- Parity (BUS_PARITY_EN): capture 32'h00000007 → bus_parity = 1; capture 32'h00000003 → bus_parity = 0.
